// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with double-buffered display data.
// The digit slot is a BLANK dead-time followed by SHOW. New data is latched only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int DIV       = 100000,
    parameter int BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        pending,
    output logic        frame_tick
);

    typedef enum logic {BLANK, SHOW} state_t;

    localparam logic [19:0] DIV_LAST   = 20'(DIV - 1);
    localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] sh_data_q, sh_data_d, ds_data_q, ds_data_d;
    logic [3:0]  sh_dp_q, sh_dp_d, ds_dp_q, ds_dp_d;
    logic        sh_lz_q, sh_lz_d, ds_lz_q, ds_lz_d;
    logic        pend_q, pend_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        tick;
    logic [15:0] upper;
    logic        suppress;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick = (state_q == SHOW) && (idx_q == 2'd3) && (cnt_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 20'd1;
        idx_d   = idx_q;
        case (state_q)
            BLANK: if (cnt_q == BLANK_LAST) begin
                state_d = SHOW;
                cnt_d   = '0;
            end
            SHOW: if (cnt_q == DIV_LAST) begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = idx_q + 2'd1;
            end
            default: state_d = BLANK;
        endcase
    end

    // A write landing on the frame boundary bypasses the shadow so it is never left pending.
    always_comb begin
        sh_data_d = sh_data_q;
        sh_dp_d   = sh_dp_q;
        sh_lz_d   = sh_lz_q;
        ds_data_d = ds_data_q;
        ds_dp_d   = ds_dp_q;
        ds_lz_d   = ds_lz_q;
        pend_d    = pend_q;
        if (wr_en) begin
            sh_data_d = wr_data;
            sh_dp_d   = dp_in;
            sh_lz_d   = lz_en;
            pend_d    = 1'b1;
        end
        if (tick) begin
            ds_data_d = sh_data_d;
            ds_dp_d   = sh_dp_d;
            ds_lz_d   = sh_lz_d;
            pend_d    = 1'b0;
        end
    end

    // Outputs are decoded from next-state values so the registered pins line up with the FSM.
    always_comb begin
        upper    = ds_data_d >> {idx_d, 2'b00};
        suppress = ds_lz_d && (idx_d != 2'd0) && (upper == 16'h0);
        an_d     = 4'b1111;
        seg_d    = 7'h7F;
        dp_d     = 1'b1;
        if (state_d == SHOW) begin
            an_d[idx_d] = 1'b0;
            seg_d       = suppress ? 7'h7F : hex7(upper[3:0]);
            dp_d        = ~ds_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            sh_lz_q   <= 1'b0;
            ds_data_q <= '0;
            ds_dp_q   <= '0;
            ds_lz_q   <= 1'b0;
            pend_q    <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_data_q <= sh_data_d;
            sh_dp_q   <= sh_dp_d;
            sh_lz_q   <= sh_lz_d;
            ds_data_q <= ds_data_d;
            ds_dp_q   <= ds_dp_d;
            ds_lz_q   <= ds_lz_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_idx  = idx_q;
    assign pending    = pend_q;
    assign frame_tick = tick;

endmodule
